// File: rtl/regs_pkg.sv
// Shared register-file constants for the writeback arbiter and its neighbours.
package regs_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;
   localparam int unsigned NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Writeback payload as it travels to the register file.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_payload_t;

endpackage

// File: rtl/regs_wb_rr_pick.sv
// Picks one valid requester, searching upward from ptr with wrap-around.
// With ptr held at zero this degenerates to lowest-index-wins priority.
module regs_wb_rr_pick #(
   parameter int unsigned N     = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic [N-1:0]     valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant_c
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant_c = '0;
      found   = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!found && valid[idx]) begin
            grant_c[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter: N producers onto one register-file write port, plus a
// pending-destination scoreboard. Define REGS_WB_RR_EN for round-robin grants.
module regs_wb_arbiter
   import regs_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DATA_W  = REG_DATA_W,
   parameter int unsigned ADDR_W  = REG_ADDR_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic                        claim_valid,
   input  logic [ADDR_W-1:0]           claim_addr,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   output logic [(1<<ADDR_W)-1:0]      pend_mask
);

   localparam int unsigned NREGS = 1 << ADDR_W;
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr;
   logic [NUM_REQ-1:0] grant_c;
   logic               xfer_c;
   logic [ADDR_W-1:0]  sel_addr_c;
   logic [DATA_W-1:0]  sel_data_c;
   logic [NREGS-1:0]   pend_next_c;

   regs_wb_rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .valid   (req_valid),
      .ptr     (ptr),
      .grant_c (grant_c)
   );

   // Nothing is accepted while reset is held.
   assign req_ready = rst ? '0 : grant_c;
   assign xfer_c    = |req_ready;

   always_comb begin
      sel_addr_c = '0;
      sel_data_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_c[i]) begin
            sel_addr_c = req_addr[i*ADDR_W +: ADDR_W];
            sel_data_c = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= xfer_c && (sel_addr_c != ADDR_W'(REG_ZERO));
         if (xfer_c) begin
            rf_waddr <= sel_addr_c;
            rf_wdata <= sel_data_c;
         end
      end
   end

   // A claim landing on the register being retired this cycle keeps it pending.
   always_comb begin
      pend_next_c = pend_mask;
      if (xfer_c) begin
         pend_next_c[sel_addr_c] = 1'b0;
      end
      if (claim_valid && (claim_addr != ADDR_W'(REG_ZERO))) begin
         pend_next_c[claim_addr] = 1'b1;
      end
      pend_next_c[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_mask <= '0;
      end else begin
         pend_mask <= pend_next_c;
      end
   end

`ifdef REGS_WB_RR_EN
   logic [PTR_W-1:0] last_c;

   always_comb begin
      last_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_c[i]) begin
            last_c = PTR_W'(i);
         end
      end
   end

   // Pointer moves one past the winner, only when something transferred.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (xfer_c) begin
         ptr <= (last_c == PTR_W'(NUM_REQ - 1)) ? '0 : last_c + PTR_W'(1);
      end
   end
`else
   assign ptr = '0;
`endif

endmodule
